// File: rtl/fifo_uart_drain.sv
// Automatic FIFO drain: pops one 15-bit word and sends it as two 8N1 UART frames,
// low byte first, with bit 7 of the high byte forced to zero.
module fifo_uart_drain #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  output logic        fifo_ren,
  input  logic [14:0] fifo_data,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  sent_count
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0]    state_r;
  logic [14:0]   word_r;
  logic          byte_sel_r;
  logic [2:0]    bit_idx_r;
  logic [BW-1:0] baud_r;
  logic [7:0]    cur_byte_s;
  logic          baud_done_s;

  // Byte currently on the wire and end-of-bit strobe
  always_comb begin
    cur_byte_s  = 8'd0;
    baud_done_s = (baud_r == BAUD_LAST);
    if (byte_sel_r) begin
      cur_byte_s = {1'b0, word_r[14:8]};
    end else begin
      cur_byte_s = word_r[7:0];
    end
  end

  // Control FSM; tx is registered from the transition so each bit lasts a full baud period
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      word_r     <= 15'd0;
      byte_sel_r <= 1'b0;
      bit_idx_r  <= 3'd0;
      baud_r     <= '0;
      fifo_ren   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      sent_count <= 8'd0;
    end else begin
      fifo_ren <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (enable && !fifo_empty) begin
            state_r  <= S_POP;
            fifo_ren <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_POP: begin
          state_r <= S_LATCH;
        end
        S_LATCH: begin
          word_r     <= fifo_data;
          byte_sel_r <= 1'b0;
          baud_r     <= '0;
          tx         <= 1'b0;
          state_r    <= S_START;
        end
        S_START: begin
          if (baud_done_s) begin
            baud_r    <= '0;
            bit_idx_r <= 3'd0;
            tx        <= cur_byte_s[0];
            state_r   <= S_DATA;
          end else begin
            baud_r <= baud_r + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done_s) begin
            baud_r <= '0;
            if (bit_idx_r == 3'd7) begin
              tx      <= 1'b1;
              state_r <= S_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              tx        <= cur_byte_s[bit_idx_r + 3'd1];
            end
          end else begin
            baud_r <= baud_r + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_done_s) begin
            baud_r <= '0;
            if (!byte_sel_r) begin
              // High byte follows with no idle gap
              byte_sel_r <= 1'b1;
              tx         <= 1'b0;
              state_r    <= S_START;
            end else begin
              busy       <= 1'b0;
              sent_count <= sent_count + 8'd1;
              state_r    <= S_IDLE;
            end
          end else begin
            baud_r <= baud_r + 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain at CLKS_PER_BIT=4 with a behavioural registered-read FIFO.
module tb_fifo_uart_drain;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty;
  logic        fifo_ren;
  logic [14:0] fifo_data = 15'd0;
  logic        tx;
  logic        busy;
  logic [7:0]  sent_count;

  fifo_uart_drain #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_ren(fifo_ren), .fifo_data(fifo_data), .tx(tx), .busy(busy),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  logic [14:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_ren) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  int ren_total = 0;
  logic prev_ren = 1'b0;
  logic double_ren = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    prev_ren <= fifo_ren;
    if (fifo_ren) ren_total <= ren_total + 1;
    if (fifo_ren && prev_ren) double_ren <= 1'b1;
  end

  typedef struct {
    logic [14:0] word;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t vecs [8];

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [14:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_ren();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fifo_ren) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ren_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at the negedge of the POP cycle; checks the whole 80-cycle word and the cycle after.
  task automatic check_word(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] exp_cnt, input int drop_at);
    logic [7:0] b;
    logic       exp_bit;
    int         j;
    chk("busy_pop", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("tx_latch", {31'd0, tx}, 32'd1);
    chk("ren_once", {31'd0, fifo_ren}, 32'd0);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (k == drop_at) enable = 1'b0;
      j = k / 4;
      b = (j < 10) ? b0 : b1;
      j = j % 10;
      if (j == 0) exp_bit = 1'b0;
      else if (j == 9) exp_bit = 1'b1;
      else exp_bit = b[j-1];
      chk("tx_bit", {31'd0, tx}, {31'd0, exp_bit});
    end
    @(negedge clk);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("tx_idle", {31'd0, tx}, 32'd1);
    chk("sent_count", {24'd0, sent_count}, {24'd0, exp_cnt});
  endtask

  int t_ren [8];
  int ren_before;

  initial begin
    vecs[0] = '{15'h1234, 8'h34, 8'h12};
    vecs[1] = '{15'h7FFF, 8'hFF, 8'h7F};
    vecs[2] = '{15'h0000, 8'h00, 8'h00};
    vecs[3] = '{15'h4A5B, 8'h5B, 8'h4A};
    vecs[4] = '{15'h00FF, 8'hFF, 8'h00};
    vecs[5] = '{15'h7F00, 8'h00, 8'h7F};
    vecs[6] = '{15'h2AD5, 8'hD5, 8'h2A};
    vecs[7] = '{15'h5555, 8'h55, 8'h55};

    repeat (2) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_ren", {31'd0, fifo_ren}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {24'd0, sent_count}, 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    @(negedge clk);

    // Table: one word at a time
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].word);
      wait_ren();
      check_word(vecs[i].b0, vecs[i].b1, 8'(i + 1), -1);
    end

    // Back-to-back: 8 words queued together
    for (int i = 0; i < 8; i++) push(vecs[i].word);
    for (int i = 0; i < 8; i++) begin
      wait_ren();
      t_ren[i] = cyc;
      check_word(vecs[i].b0, vecs[i].b1, 8'(9 + i), -1);
    end
    for (int i = 1; i < 8; i++) chk("ren_spacing", 32'(t_ren[i] - t_ren[i-1]), 32'd83);
    repeat (200) @(negedge clk);
    chk("no_ninth_pop", 32'(ren_total), 32'd16);
    chk("fifo_drained", {31'd0, fifo_empty}, 32'd1);

    // Enable drop during byte0 data bits
    do_reset();
    for (int i = 0; i < 3; i++) push(vecs[i].word);
    wait_ren();
    check_word(vecs[0].b0, vecs[0].b1, 8'd1, 6);
    ren_before = ren_total;
    repeat (150) @(negedge clk);
    chk("drop_no_pop", 32'(ren_total), 32'(ren_before));
    chk("drop_count", {24'd0, sent_count}, 32'd1);
    enable = 1'b1;
    wait_ren();
    check_word(vecs[1].b0, vecs[1].b1, 8'd2, -1);
    wait_ren();
    check_word(vecs[2].b0, vecs[2].b1, 8'd3, -1);

    // Reset during byte1 DATA
    push(vecs[3].word);
    push(vecs[4].word);
    wait_ren();
    repeat (51) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_count", {24'd0, sent_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_ren();
    check_word(vecs[4].b0, vecs[4].b1, 8'd1, -1);

    // Counter wrap over 256 words
    do_reset();
    for (int i = 0; i < 256; i++) push(15'(i * 7));
    for (int w = 1; w <= 256; w++) begin
      wait_ren();
      repeat (82) @(negedge clk);
      if (w == 255) chk("count_255", {24'd0, sent_count}, 32'd255);
      if (w == 256) chk("count_wrap", {24'd0, sent_count}, 32'd0);
    end
    chk("wrap_busy", {31'd0, busy}, 32'd0);
    chk("ren_not_consecutive", {31'd0, double_ren}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_drain.md
# fifo_uart_drain

Read-side consumer for the 8-deep, 15-bit FIFO. Whenever the FIFO is non-empty and draining is enabled, the block pops one word through the FIFO's `empty` / read-enable / read-data interface. It then transmits that word as two back-to-back 8N1 UART frames on a single `tx` line, low byte first. It sits between the FIFO memory read port and the board's serial pin, replacing the button-driven read path when the FIFO is drained automatically.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (434 = 115200 baud at 50 MHz). Legal range is ≥ 2.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; when high, the block may start popping words.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_ren`  out  1  one-cycle read-enable pulse to the FIFO.
- `fifo_data`  in  15  FIFO read data; valid one cycle after `fifo_ren` (registered read).
- `tx`  out  1  UART serial output; idle high.
- `busy`  out  1  high from the `fifo_ren` cycle through the end of the last stop bit.
- `sent_count`  out  8  number of words fully transmitted; wraps modulo 256.

## Operation
- Reset values: `tx`=1, `fifo_ren`=0, `busy`=0, `sent_count`=0, state IDLE, internal word register and counters cleared.
- States:
  - IDLE: the block stays here until `enable` && !`fifo_empty`, then moves to POP.
  - POP: `fifo_ren`=1 for exactly this cycle, then moves to LATCH.
  - LATCH: captures `fifo_data` into the word register and sets byte_sel=0, then moves to START.
  - START, DATA, STOP: serialise one byte, then branch on byte_sel:
    - byte_sel=0: set byte_sel=1 and go to START.
    - byte_sel=1: go to IDLE.
- Byte mapping:
  - byte0 = word[7:0].
  - byte1 = {1'b0, word[14:8]}. Bit 7 of byte1 is always 0.
- Frame format: start bit 0, data bits 0..7 LSB first, stop bit 1. Each bit is held for exactly `CLKS_PER_BIT` cycles by a baud counter. A 3-bit index selects the data bit.
- No idle gap between byte0's stop bit and byte1's start bit.
- `sent_count` increments by 1 in the last cycle of byte1's stop bit. 255 wraps to 0.
- `enable` falling mid-word: the current word completes; no new pop occurs.
- `fifo_empty` or `fifo_data` changing after LATCH: ignored for the current word.
- `fifo_empty` rising in the POP cycle cannot occur from the FIFO side. It is not checked.
- Reset asserted mid-frame:
  - `tx` goes to 1 and `busy` to 0 immediately (asynchronously).
  - The popped word is discarded, not retried.
  - `sent_count` clears.

## Timing
- Cycle t: IDLE with `enable`=1 and `fifo_empty`=0 sampled.
- Cycle t+1: POP, `fifo_ren`=1, `busy`=1.
- Cycle t+2: LATCH, data sampled.
- Cycle t+3: `tx` falls (start bit of byte0).
- Each frame lasts 10·`CLKS_PER_BIT` cycles. One word occupies `tx` for 20·`CLKS_PER_BIT` cycles, from t+3 through t+2+20·`CLKS_PER_BIT`.
- `busy` falls and IDLE is re-entered the cycle after the final stop-bit cycle. The earliest next `fifo_ren` is one cycle later.
- Minimum word period is 20·`CLKS_PER_BIT`+3 cycles.
- All outputs are registered. `fifo_ren` is never asserted in two consecutive cycles.

## Test plan
All scenarios use `CLKS_PER_BIT`=4.
- Single word: FIFO holds 15'h1234, `enable`=1.
  - Required: one `fifo_ren` pulse.
  - `tx` carries frame 0x34 then 0x12: bits, 4 cycles each, are 0,0,0,1,0,1,1,0,0,1 then 0,0,1,0,0,1,0,0,0,1.
  - `sent_count`=1 and `busy`=0 at cycle t+83.
- Upper bit masking: word 15'h7FFF.
  - Required: byte0 = 0xFF, byte1 = 0x7F, with byte1 data bit 7 = 0 on `tx`.
- Back-to-back: FIFO holds 8 words, `enable` held high.
  - Required: 8 `fifo_ren` pulses spaced exactly 83 cycles apart.
  - `sent_count`=8 at the end; `fifo_empty` rises and no ninth pop occurs.
- Enable drop: deassert `enable` during byte0 data bits with 3 words queued.
  - Required: the current word completes on `tx`; no further `fifo_ren`; `sent_count`=1.
  - Reasserting `enable` resumes with the next word.
- Reset mid-frame: assert `reset` during byte1 DATA.
  - Required: `tx`=1, `busy`=0, `sent_count`=0 in the same cycle.
  - After release, the next queued word is popped cleanly.
- Counter wrap: transmit 256 words.
  - Required: `sent_count` reads 255 after word 255 and 0 after word 256.
